mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single backing memory between I-cache and D-cache miss/fill traffic in the pipelined processor.
- Grants one requester at a time and holds the grant until the memory reports completion.
- Routes read data and a done strobe back to the granted requester.
- D-side has priority; a starvation limit guarantees forward progress for fetch.

Parameters:
ADDR_W, 16, address width of requests and memory port
DATA_W, 16, data width of read/write paths
STARVE_LIMIT, 4, consecutive D grants allowed while i_req is pending before I is forced; range 1..7

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_req  in  1  I-cache read request; held until i_done
i_addr  in  ADDR_W  I-cache read address
i_done  out  1  one-cycle completion strobe to I-cache
i_rdata  out  DATA_W  read data to I-cache; valid when i_done=1
d_req  in  1  D-cache request; held until d_done
d_wr  in  1  D-cache request is a write (1) or read (0)
d_addr  in  ADDR_W  D-cache address
d_wdata  in  DATA_W  D-cache write data
d_done  out  1  one-cycle completion strobe to D-cache
d_rdata  out  DATA_W  read data to D-cache; valid when d_done=1 and the request was a read
mem_req  out  1  request to backing memory; level, held until mem_done
mem_wr  out  1  write enable to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid with mem_done
mem_done  in  1  memory completion strobe
busy  out  1  a transaction is in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; mem_req, mem_wr, i_done, d_done and busy are 0; mem_addr, mem_wdata and the starvation counter are 0.
- States:
  - IDLE: no transaction.
  - GNT_I: I-cache granted.
  - GNT_D: D-cache granted.
- Arbitration happens in IDLE only, sampled at posedge clk:
  - d_req=1, and either i_req=0 or starve_cnt<STARVE_LIMIT: go to GNT_D.
  - else if i_req=1: go to GNT_I.
  - else: stay in IDLE.
- Grant entry: the request fields are captured into registered mem_addr, mem_wr and mem_wdata.
  - GNT_I captures mem_wr=0 and mem_wdata=0.
  - mem_req=1 from the first cycle in the GNT state.
  - The fields stay stable until mem_done, even if the requester's inputs change.
- Completion in GNT_x with mem_done=1:
  - x_done=1 combinationally in that same cycle.
  - x_rdata=mem_rdata in that cycle.
  - Next state is IDLE; mem_req and mem_wr drop at that edge.
- Latency and throughput:
  - Minimum request-to-done latency is 1 + memory latency cycles.
  - There is one mandatory IDLE cycle between transactions.
- Done outputs: i_done and d_done are never both 1. Neither is asserted in IDLE.
- i_rdata and d_rdata carry mem_rdata gated by their done strobe; they are 0 otherwise.
- Starvation counter (3-bit, saturating at STARVE_LIMIT):
  - On a D grant while i_req=1: increment.
  - On any I grant: clear.
  - On a D grant with i_req=0: clear.
- mem_done in IDLE is ignored, with no done strobes.
- The requester must keep req high until its done. A req dropped mid-transaction does not abort the memory access; the done strobe still fires.
- Reset mid-transaction: the transaction is abandoned immediately and all outputs take their reset values. No done is issued for the abandoned request.
- A requester re-asserting req in the cycle after its done competes normally in IDLE.

Test Plan:
- Single I read: i_req=1, i_addr=0x0040; memory returns 0xBEEF after 3 cycles -> mem_req high for cycles 1–4, mem_addr=0x0040, mem_wr=0; i_done=1 with i_rdata=0xBEEF in the mem_done cycle; busy=0 next cycle.
- D write: d_req=1, d_wr=1, d_addr=0x1234, d_wdata=0x5A5A -> mem_wr=1, mem_addr=0x1234, mem_wdata=0x5A5A held until mem_done; d_done pulses once; i_done stays 0.
- Simultaneous requests: i_req and d_req rise in the same cycle with starve_cnt=0 -> D served first; I granted in the arbitration after the IDLE cycle.
- Starvation: i_req held while d_req continuously re-requests, STARVE_LIMIT=4 -> exactly 4 D grants, then a GNT_I; starve_cnt returns to 0.
- Input change during grant: d_addr changes from 0x0010 to 0x0020 while in GNT_D -> mem_addr stays 0x0010 until mem_done.
- Reset mid-operation: rst asserted two cycles into GNT_D (asynchronously, between edges) -> mem_req, busy and d_done go to 0 immediately. A mem_done arriving afterwards produces no done strobe; the next d_req is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one backing memory between I-cache and D-cache. D wins by default, but a saturating
// starvation counter forces an I grant. The grant is held until mem_done.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state, next_state;
  logic [2:0] starve_cnt;
  logic       grant_i, grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || starve_cnt < LIMIT)) begin
          grant_d    = 1'b1;
          next_state = GNT_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          next_state = GNT_I;
        end
      end
      GNT_I, GNT_D: if (mem_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are latched at grant so requester changes mid-transaction are invisible to memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      starve_cnt <= 3'd0;
    end else if (grant_d) begin
      mem_addr  <= d_addr;
      mem_wr    <= d_wr;
      mem_wdata <= d_wdata;
      if (!i_req)                  starve_cnt <= 3'd0;
      else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 3'd1;
    end else if (grant_i) begin
      mem_addr   <= i_addr;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      starve_cnt <= 3'd0;
    end else if (state != IDLE && mem_done) begin
      mem_wr <= 1'b0;
    end
  end

  assign mem_req = (state != IDLE);
  assign busy    = (state != IDLE);
  assign i_done  = (state == GNT_I) && mem_done;
  assign d_done  = (state == GNT_D) && mem_done;
  assign i_rdata = i_done ? mem_rdata : '0;
  assign d_rdata = d_done ? mem_rdata : '0;

endmodule
